// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage stall requests and commit events in,
// stall/flush controls and performance counters out.
interface pipe_ctrl_if;
  logic        if_stallreq;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic        mem_stallreq;
  logic        excp_valid;
  logic [31:0] excp_vector;
  logic        eret_valid;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        busy;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  // Debug view of the controller FSM state (IDLE=0, PEND=1, FLUSH=2).
  logic [1:0]  dbg_state;

  modport master (
    output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    output excp_valid, excp_vector, eret_valid, epc,
    input  stall, flush, flush_pc, busy, stall_cycles, flush_count, dbg_state
  );

  modport slave (
    input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    input  excp_valid, excp_vector, eret_valid, epc,
    output stall, flush, flush_pc, busy, stall_cycles, flush_count, dbg_state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception/ERET redirect FSM.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input logic      clk,
  input logic      rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] target;
  logic [31:0] target_nxt;
  logic        event_req;
  logic        in_flush;
  logic [5:0]  stall_req;
  logic [5:0]  stall_out;

  // Highest requesting stage freezes itself and everything upstream.
  always_comb begin
    stall_req = 6'b000000;
    if (bus.mem_stallreq)
      stall_req = 6'b011111;
    else if (bus.ex_stallreq)
      stall_req = 6'b001111;
    else if (bus.id_stallreq)
      stall_req = 6'b000111;
    else if (bus.if_stallreq)
      stall_req = 6'b000011;
  end

  assign event_req = bus.excp_valid | bus.eret_valid;

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    case (state)
      IDLE: begin
        if (event_req) begin
          target_nxt = bus.excp_valid ? bus.excp_vector : bus.epc;
          state_nxt  = bus.mem_stallreq ? PEND : FLUSH;
        end
      end
      PEND: begin
        if (!bus.mem_stallreq)
          state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      target <= 32'd0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
    end
  end

  // Reset masks the flush decode so an aborted event never pulses flush.
  assign in_flush  = (state == FLUSH) && !rst;
  assign stall_out = in_flush ? 6'b000000 : stall_req;

  assign bus.stall     = stall_out;
  assign bus.flush     = in_flush;
  assign bus.flush_pc  = target;
  assign bus.busy      = (state != IDLE) && !rst;
  assign bus.dbg_state = state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (|stall_out)
        stall_cnt <= stall_cnt + 32'd1;
      if (in_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 16'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port if_stallreq, input, 1 bit: the fetch stage requests a stall.
REQ-004 The block SHALL have the port id_stallreq, input, 1 bit: the decode stage requests a stall (load-use hazard).
REQ-005 The block SHALL have the port ex_stallreq, input, 1 bit: the execute stage requests a stall (multi-cycle mul/div).
REQ-006 The block SHALL have the port mem_stallreq, input, 1 bit: the memory stage requests a stall (data bus wait).
REQ-007 The block SHALL have the port excp_valid, input, 1 bit: the memory stage commits an exception.
REQ-008 The block SHALL have the port excp_vector, input, 32 bits: the handler address for excp_valid.
REQ-009 The block SHALL have the port eret_valid, input, 1 bit: the memory stage commits ERET.
REQ-010 The block SHALL have the port epc, input, 32 bits: the return address for eret_valid.
REQ-011 The block SHALL have the port stall, output, 6 bits: {wb, mem, ex, id, if, pc} stage stalls, feeding the pipeline registers' *_stall inputs.
REQ-012 The block SHALL have the port flush, output, 1 bit: clears all pipeline registers; this is the flush input of every pipeline register.
REQ-013 The block SHALL have the port flush_pc, output, 32 bits: the PC redirect target, valid while flush=1.
REQ-014 The block SHALL have the port busy, output, 1 bit: the FSM is not in IDLE.
REQ-015 The block SHALL have the port stall_cycles, output, 32 bits: the performance counter (see Configuration).
REQ-016 The block SHALL have the port flush_count, output, 16 bits: the performance counter (see Configuration).

Function
REQ-017 The stall output SHALL be combinational from the requests, with priority mem > ex > id > if: mem gives 6'b011111; ex gives 6'b001111; id gives 6'b000111; if gives 6'b000011; no request gives 6'b000000.
REQ-018 A stall request from stage k SHALL freeze stage k and all earlier stages, while stage k+1 sees stall=0 and therefore receives a bubble.
REQ-019 The FSM SHALL have the states IDLE, PEND and FLUSH, encoded in 2 bits; busy SHALL be 1 in PEND and FLUSH.
REQ-020 In IDLE, when excp_valid or eret_valid is 1 and mem_stallreq=0, the block SHALL latch the target and go to FLUSH next cycle.
REQ-021 In IDLE, when excp_valid or eret_valid is 1 and mem_stallreq=1, the block SHALL latch the target and go to PEND.
REQ-022 The latched target SHALL be excp_vector if excp_valid=1, otherwise epc; excp_valid has priority over eret_valid when both are 1.
REQ-023 In PEND, the block SHALL stay while mem_stallreq=1 and go to FLUSH in the cycle after mem_stallreq=0; stall SHALL follow REQ-017 meanwhile.
REQ-024 In FLUSH, flush SHALL be 1 and flush_pc SHALL equal the latched target, stall SHALL be forced to 6'b000000 regardless of requests, and the next state SHALL be IDLE.
REQ-025 flush SHALL be a registered-state decode: it is 1 only in FLUSH and lasts exactly one cycle per accepted event.
REQ-026 The block SHALL ignore excp_valid and eret_valid while in PEND or FLUSH; no event is queued.
REQ-027 When not in FLUSH, flush_pc SHALL hold its last latched value.

Reset
REQ-028 When rst=1 at a rising edge, the block SHALL go to IDLE and clear flush_pc, stall_cycles and flush_count to 0.
REQ-029 During reset, flush=0 and busy=0 and stall SHALL follow the combinational rule of REQ-017.
REQ-030 A reset asserted in PEND or FLUSH SHALL abort the event with no flush pulse.

Configuration
REQ-031 When macro PIPE_CTRL_PERF_EN is defined, stall_cycles SHALL increment by 1 each cycle in which stall is nonzero and wrap at 2^32.
REQ-032 When PIPE_CTRL_PERF_EN is defined, flush_count SHALL increment by 1 on each FLUSH cycle and saturate at 16'hFFFF.
REQ-033 When PIPE_CTRL_PERF_EN is undefined, stall_cycles and flush_count SHALL be constant 0 and no counter flops SHALL be instantiated.

Verification
REQ-034 The bench SHALL check stall priority: ex_stallreq=1 with id_stallreq=1 -> stall=6'b001111; mem_stallreq=1 added -> stall=6'b011111.
REQ-035 The bench SHALL check an exception: excp_valid=1, excp_vector=32'hBFC00380, no stall -> next cycle flush=1 and flush_pc=32'hBFC00380 for exactly 1 cycle, then busy=0.
REQ-036 The bench SHALL check a pending exception: excp_valid=1 with mem_stallreq=1 held 3 cycles -> state PEND for 3 cycles, stall=6'b011111, then flush the cycle after mem_stallreq falls.
REQ-037 The bench SHALL check simultaneous events: excp_valid=1, eret_valid=1, epc=32'h80001000 -> flush_pc=excp_vector; a second excp_valid during FLUSH -> no second flush pulse.
REQ-038 The bench SHALL check a flush override: id_stallreq=1 in the FLUSH cycle -> stall=0 that cycle; rst=1 in PEND -> IDLE, no flush.
REQ-039 The bench SHALL check the counters with PIPE_CTRL_PERF_EN defined: 5 stall cycles and 2 flushes -> stall_cycles=5 and flush_count=2; with the macro undefined both are 0.
